// File: rtl/flp_multiplier_pipelined.sv
// rtl/flp_multiplier_pipelined.sv - 4-stage IEEE-754 multiplier with RTZ/RNE rounding, specials and stall
// Stages: S1 unpack/classify, S2 significand product, S3 normalise/round, S4 pack into output regs.
module flp_multiplier_pipelined #(
  parameter int EXP_BITS  = 11,
  parameter int MANT_BITS = 52,
  localparam int W = 1 + EXP_BITS + MANT_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_overflow,
  output logic         flag_underflow,
  output logic         flag_invalid
);

  localparam int EW   = EXP_BITS + 2;
  localparam int PW   = 2 * MANT_BITS + 2;
  localparam int BIAS = (1 << (EXP_BITS - 1)) - 1;

  localparam logic [EW-1:0] EMAX     = EW'((1 << EXP_BITS) - 1);
  localparam logic [W-1:0]  QNAN     = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
  localparam logic [W-2:0]  INF_MAG  = {{EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
  localparam logic [W-2:0]  MAXF_MAG = {{(EXP_BITS-1){1'b1}}, 1'b0, {MANT_BITS{1'b1}}};

  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  logic [EXP_BITS-1:0]  w_ea, w_eb;
  logic [MANT_BITS-1:0] w_fa, w_fb;
  logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [EW-1:0]        w_esum;

  assign w_ea     = a[W-2:MANT_BITS];
  assign w_eb     = b[W-2:MANT_BITS];
  assign w_fa     = a[MANT_BITS-1:0];
  assign w_fb     = b[MANT_BITS-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);
  // Two's-complement in EW bits: stays representable for every pair of exponent fields
  assign w_esum   = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);

  logic                 r_s1_valid, r_s1_sign, r_s1_invalid, r_s1_inf, r_s1_zero, r_s1_rnd;
  logic [EW-1:0]        r_s1_esum;
  logic [MANT_BITS:0]   r_s1_ma, r_s1_mb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_invalid <= 1'b0;
      r_s1_inf     <= 1'b0;
      r_s1_zero    <= 1'b0;
      r_s1_rnd     <= 1'b0;
      r_s1_esum    <= '0;
      r_s1_ma      <= '0;
      r_s1_mb      <= '0;
    end else if (w_en) begin
      r_s1_valid   <= in_valid;
      r_s1_sign    <= a[W-1] ^ b[W-1];
      r_s1_invalid <= w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
      r_s1_inf     <= w_a_inf || w_b_inf;
      r_s1_zero    <= w_a_zero || w_b_zero;
      r_s1_rnd     <= rnd_mode;
      r_s1_esum    <= w_esum;
      r_s1_ma      <= {1'b1, w_fa};
      r_s1_mb      <= {1'b1, w_fb};
    end
  end

  logic                 r_s2_valid, r_s2_sign, r_s2_invalid, r_s2_inf, r_s2_zero, r_s2_rnd;
  logic [EW-1:0]        r_s2_esum;
  logic [PW-1:0]        r_s2_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_invalid <= 1'b0;
      r_s2_inf     <= 1'b0;
      r_s2_zero    <= 1'b0;
      r_s2_rnd     <= 1'b0;
      r_s2_esum    <= '0;
      r_s2_prod    <= '0;
    end else if (w_en) begin
      r_s2_valid   <= r_s1_valid;
      r_s2_sign    <= r_s1_sign;
      r_s2_invalid <= r_s1_invalid;
      r_s2_inf     <= r_s1_inf;
      r_s2_zero    <= r_s1_zero;
      r_s2_rnd     <= r_s1_rnd;
      r_s2_esum    <= r_s1_esum;
      r_s2_prod    <= PW'(r_s1_ma) * PW'(r_s1_mb);
    end
  end

  // w_norm drops the leading one: fraction on top, then guard, then sticky bits
  logic                 w_msb, w_guard, w_sticky, w_inc;
  logic [PW-2:0]        w_norm;
  logic [MANT_BITS-1:0] w_frac;
  logic [MANT_BITS:0]   w_rsum;
  logic [EW-1:0]        w_esum_r;

  assign w_msb    = r_s2_prod[PW-1];
  assign w_norm   = w_msb ? r_s2_prod[PW-2:0] : {r_s2_prod[PW-3:0], 1'b0};
  assign w_frac   = w_norm[PW-2:MANT_BITS+1];
  assign w_guard  = w_norm[MANT_BITS];
  assign w_sticky = |w_norm[MANT_BITS-1:0];
  assign w_inc    = r_s2_rnd && w_guard && (w_sticky || w_frac[0]);
  assign w_rsum   = {1'b0, w_frac} + (MANT_BITS+1)'(w_inc);
  assign w_esum_r = r_s2_esum + EW'(w_msb) + EW'(w_rsum[MANT_BITS]);

  logic                 r_s3_valid, r_s3_sign, r_s3_invalid, r_s3_inf, r_s3_zero, r_s3_rnd;
  logic [EW-1:0]        r_s3_esum;
  logic [MANT_BITS-1:0] r_s3_frac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3_valid   <= 1'b0;
      r_s3_sign    <= 1'b0;
      r_s3_invalid <= 1'b0;
      r_s3_inf     <= 1'b0;
      r_s3_zero    <= 1'b0;
      r_s3_rnd     <= 1'b0;
      r_s3_esum    <= '0;
      r_s3_frac    <= '0;
    end else if (w_en) begin
      r_s3_valid   <= r_s2_valid;
      r_s3_sign    <= r_s2_sign;
      r_s3_invalid <= r_s2_invalid;
      r_s3_inf     <= r_s2_inf;
      r_s3_zero    <= r_s2_zero;
      r_s3_rnd     <= r_s2_rnd;
      r_s3_esum    <= w_esum_r;
      r_s3_frac    <= w_rsum[MANT_BITS-1:0];
    end
  end

  logic         w_over, w_under, w_ovf, w_unf, w_inv;
  logic [W-1:0] w_res;

  assign w_over  = !r_s3_esum[EW-1] && (r_s3_esum >= EMAX);
  assign w_under = r_s3_esum[EW-1] || (r_s3_esum == '0);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    if (r_s3_invalid) begin
      w_res = QNAN;
      w_inv = 1'b1;
    end else if (r_s3_inf) begin
      w_res = {r_s3_sign, INF_MAG};
    end else if (r_s3_zero) begin
      w_res = {r_s3_sign, {(W-1){1'b0}}};
    end else if (w_over) begin
      w_ovf = 1'b1;
      w_res = r_s3_rnd ? {r_s3_sign, INF_MAG} : {r_s3_sign, MAXF_MAG};
    end else if (w_under) begin
      w_unf = 1'b1;
      w_res = {r_s3_sign, {(W-1){1'b0}}};
    end else begin
      w_res = {r_s3_sign, r_s3_esum[EXP_BITS-1:0], r_s3_frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      result         <= '0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_invalid   <= 1'b0;
    end else if (w_en) begin
      out_valid      <= r_s3_valid;
      result         <= r_s3_valid ? w_res : '0;
      flag_overflow  <= r_s3_valid && w_ovf;
      flag_underflow <= r_s3_valid && w_unf;
      flag_invalid   <= r_s3_valid && w_inv;
    end
  end

endmodule
